// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite command-port arbiter.
//   - AXI4-Lite response codes
//   - default address/data widths
//   - arbiter FSM state encoding
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_RESP = 3'd2,
    R_ADDR = 3'd3,
    R_DATA = 3'd4,
    DONE   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_master_arbiter_if.sv
// Bundle of requester-side, master-command and bus-snoop signals of the
// arbiter.
//   modport slave  : the arbiter (consumes requests and snoop, drives
//                    acks/dones/read return and the master command inputs)
//   modport master : the environment (requesters, master and slave)
interface axi4_lite_master_arbiter_if
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) ();

  // requester side
  logic [NUM_REQ-1:0]          iREQ_WR;
  logic [NUM_REQ-1:0]          iREQ_RD;
  logic [NUM_REQ*ADDR_W-1:0]   iREQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0]   iREQ_WDATA;
  logic [NUM_REQ*DATA_W/8-1:0] iREQ_WSTRB;
  logic [NUM_REQ-1:0]          oREQ_ACK;
  logic [NUM_REQ-1:0]          oREQ_DONE;
  logic [DATA_W-1:0]           oREQ_RDATA;
  logic [1:0]                  oREQ_RESP;

  // master command inputs
  logic                        oWRITE_START;
  logic                        oREAD_START;
  logic [ADDR_W-1:0]           oWRITE_ADDR;
  logic [DATA_W-1:0]           oWRITE_DATA;
  logic [DATA_W/8-1:0]         oWRITE_STRB;
  logic [ADDR_W-1:0]           oREAD_ADDR;

  // bus snoop
  logic                        iAWVALID, iAWREADY, iARVALID, iARREADY;
  logic                        iBVALID, iBREADY, iRVALID, iRREADY;
  logic [1:0]                  iBRESP;
  logic [1:0]                  iRRESP;
  logic [DATA_W-1:0]           iRDATA;

  modport slave (
    input  iREQ_WR, iREQ_RD, iREQ_ADDR, iREQ_WDATA, iREQ_WSTRB,
    input  iAWVALID, iAWREADY, iARVALID, iARREADY,
    input  iBVALID, iBREADY, iRVALID, iRREADY, iBRESP, iRRESP, iRDATA,
    output oREQ_ACK, oREQ_DONE, oREQ_RDATA, oREQ_RESP,
    output oWRITE_START, oREAD_START, oWRITE_ADDR, oWRITE_DATA,
    output oWRITE_STRB, oREAD_ADDR
  );

  modport master (
    output iREQ_WR, iREQ_RD, iREQ_ADDR, iREQ_WDATA, iREQ_WSTRB,
    output iAWVALID, iAWREADY, iARVALID, iARREADY,
    output iBVALID, iBREADY, iRVALID, iRREADY, iBRESP, iRRESP, iRDATA,
    input  oREQ_ACK, oREQ_DONE, oREQ_RDATA, oREQ_RESP,
    input  oWRITE_START, oREAD_START, oWRITE_ADDR, oWRITE_DATA,
    input  oWRITE_STRB, oREAD_ADDR
  );

endinterface

// File: rtl/axi4_lite_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 (mod N)
//   gnt : one-hot grant, all zero when no request is set
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master command port among NUM_REQ
// requesters. One transaction is in flight at a time; AW/AR/B/R handshakes
// are snooped to detect address acceptance and completion.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus        : requester, master-command and snoop signals (slave modport)
module axi4_lite_master_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic                  iCLK,
  input logic                  iRST,
  axi4_lite_master_arbiter_if.slave bus
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, gidx_q, gidx_d, g_idx;
  logic [NUM_REQ-1:0]  req, gnt;
  logic [NUM_REQ-1:0]  ack_q, ack_d, done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                wstart_q, wstart_d, rstart_q, rstart_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_hs, ar_hs, b_hs, r_hs;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = PTR_W'(i);
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign req   = bus.iREQ_WR | bus.iREQ_RD;
  assign g_idx = onehot_to_idx(gnt);
  assign aw_hs = bus.iAWVALID & bus.iAWREADY;
  assign ar_hs = bus.iARVALID & bus.iARREADY;
  assign b_hs  = bus.iBVALID & bus.iBREADY;
  assign r_hs  = bus.iRVALID & bus.iRREADY;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // next-state and next-output logic; every output is registered, so the
  // DONE pulse is loaded on the edge that enters DONE
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    ack_d    = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    wstart_d = wstart_q;
    rstart_d = rstart_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    raddr_d  = raddr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ack_d  = gnt;
          ptr_d  = g_idx;
          gidx_d = g_idx;
          // a simultaneous read stays pending for a later pass
          if (bus.iREQ_WR[g_idx]) begin
            state_d  = W_ADDR;
            wstart_d = 1'b1;
            waddr_d  = bus.iREQ_ADDR[g_idx*ADDR_W +: ADDR_W];
            wdata_d  = bus.iREQ_WDATA[g_idx*DATA_W +: DATA_W];
            wstrb_d  = bus.iREQ_WSTRB[g_idx*STRB_W +: STRB_W];
          end else begin
            state_d  = R_ADDR;
            rstart_d = 1'b1;
            raddr_d  = bus.iREQ_ADDR[g_idx*ADDR_W +: ADDR_W];
          end
        end
      end
      W_ADDR: begin
        if (aw_hs) begin
          wstart_d = 1'b0;
          // zero-latency slave: response in the same cycle as acceptance
          if (b_hs) begin
            resp_d  = bus.iBRESP;
            done_d  = idx_to_onehot(gidx_q);
            state_d = DONE;
          end else begin
            state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          resp_d  = bus.iBRESP;
          done_d  = idx_to_onehot(gidx_q);
          state_d = DONE;
        end
      end
      R_ADDR: begin
        if (ar_hs) begin
          rstart_d = 1'b0;
          if (r_hs) begin
            rdata_d = bus.iRDATA;
            resp_d  = bus.iRRESP;
            done_d  = idx_to_onehot(gidx_q);
            state_d = DONE;
          end else begin
            state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rdata_d = bus.iRDATA;
          resp_d  = bus.iRRESP;
          done_d  = idx_to_onehot(gidx_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pointer resets to the last index so requester 0 wins the first pass
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      gidx_q   <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      resp_q   <= '0;
      wstart_q <= 1'b0;
      rstart_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      wstart_q <= wstart_d;
      rstart_q <= rstart_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      raddr_q  <= raddr_d;
    end
  end

  assign bus.oREQ_ACK     = ack_q;
  assign bus.oREQ_DONE    = done_q;
  assign bus.oREQ_RDATA   = rdata_q;
  assign bus.oREQ_RESP    = resp_q;
  assign bus.oWRITE_START = wstart_q;
  assign bus.oREAD_START  = rstart_q;
  assign bus.oWRITE_ADDR  = waddr_q;
  assign bus.oWRITE_DATA  = wdata_q;
  assign bus.oWRITE_STRB  = wstrb_q;
  assign bus.oREAD_ADDR   = raddr_q;

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Bench for axi4_lite_master_arbiter: directed requests, a scripted
// master/slave bus model, and a scoreboard monitor for ACK and DONE pulses.
module tb_axi4_lite_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4_lite_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ack_exp_t;

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } done_exp_t;

  ack_exp_t  ack_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;

  // bus model knobs
  int          aw_dly = 3;
  int          b_dly = 1;
  bit          same_cyc = 1'b0;
  logic [1:0]  bresp_v = 2'b00;
  logic [1:0]  rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;

  // master + slave model: reacts to START, performs address then response
  initial begin
    bus.iAWVALID = 0; bus.iAWREADY = 0; bus.iARVALID = 0; bus.iARREADY = 0;
    bus.iBVALID = 0; bus.iBREADY = 0; bus.iRVALID = 0; bus.iRREADY = 0;
    bus.iBRESP = 0; bus.iRRESP = 0; bus.iRDATA = 0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.oWRITE_START) begin
        bus.iAWVALID = 1;
        repeat (aw_dly) @(negedge clk);
        bus.iAWREADY = 1;
        if (same_cyc) begin bus.iBVALID = 1; bus.iBREADY = 1; bus.iBRESP = bresp_v; end
        @(negedge clk);
        bus.iAWVALID = 0; bus.iAWREADY = 0;
        if (same_cyc) begin
          bus.iBVALID = 0; bus.iBREADY = 0;
        end else begin
          repeat (b_dly) @(negedge clk);
          bus.iBVALID = 1; bus.iBREADY = 1; bus.iBRESP = bresp_v;
          @(negedge clk);
          bus.iBVALID = 0; bus.iBREADY = 0;
        end
      end else if (bus.oREAD_START) begin
        bus.iARVALID = 1;
        repeat (aw_dly) @(negedge clk);
        bus.iARREADY = 1;
        if (same_cyc) begin bus.iRVALID = 1; bus.iRREADY = 1; bus.iRRESP = rresp_v; bus.iRDATA = rdata_v; end
        @(negedge clk);
        bus.iARVALID = 0; bus.iARREADY = 0;
        if (same_cyc) begin
          bus.iRVALID = 0; bus.iRREADY = 0;
        end else begin
          repeat (b_dly) @(negedge clk);
          bus.iRVALID = 1; bus.iRREADY = 1; bus.iRRESP = rresp_v; bus.iRDATA = rdata_v;
          @(negedge clk);
          bus.iRVALID = 0; bus.iRREADY = 0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    ack_exp_t  ea;
    done_exp_t ed;
    logic [N-1:0] oh;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.oREQ_ACK != '0) begin
        checks++;
        ack_cnt++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got ack=%b, required no ack", bus.oREQ_ACK);
        end else begin
          ea = ack_q.pop_front();
          oh = '0; oh[ea.idx] = 1'b1;
          if (ea.wr)
            ok = (bus.oREQ_ACK == oh) && bus.oWRITE_START && !bus.oREAD_START &&
                 (bus.oWRITE_ADDR == ea.addr) && (bus.oWRITE_DATA == ea.data) &&
                 (bus.oWRITE_STRB == ea.strb);
          else
            ok = (bus.oREQ_ACK == oh) && bus.oREAD_START && !bus.oWRITE_START &&
                 (bus.oREAD_ADDR == ea.addr);
          if (!ok) begin
            errors++;
            $display("FAIL ack_grant: got ack=%b ws=%b rs=%b waddr=%h wdata=%h wstrb=%h raddr=%h, required ack=%b wr=%0d addr=%h data=%h strb=%h",
                     bus.oREQ_ACK, bus.oWRITE_START, bus.oREAD_START, bus.oWRITE_ADDR,
                     bus.oWRITE_DATA, bus.oWRITE_STRB, bus.oREAD_ADDR, oh, ea.wr, ea.addr, ea.data, ea.strb);
          end
        end
      end
      if (bus.oREQ_DONE != '0) begin
        checks++;
        done_cnt++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done=%b, required no done", bus.oREQ_DONE);
        end else begin
          ed = done_q.pop_front();
          oh = '0; oh[ed.idx] = 1'b1;
          ok = (bus.oREQ_DONE == oh) && (bus.oREQ_RESP == ed.resp) &&
               (!ed.rd || (bus.oREQ_RDATA == ed.rdata));
          if (!ok) begin
            errors++;
            $display("FAIL done_result: got done=%b resp=%b rdata=%h, required done=%b resp=%b rdata=%h (rd=%0d)",
                     bus.oREQ_DONE, bus.oREQ_RESP, bus.oREQ_RDATA, oh, ed.resp, ed.rdata, ed.rd);
          end
        end
      end
    end
  end

  task automatic exp_ack(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ack_exp_t e;
    e.idx = i; e.wr = wr; e.addr = a; e.data = d; e.strb = s;
    ack_q.push_back(e);
  endtask

  task automatic exp_done(input int i, input bit rd, input logic [31:0] rdat, input logic [1:0] rsp);
    done_exp_t e;
    e.idx = i; e.rd = rd; e.rdata = rdat; e.resp = rsp;
    done_q.push_back(e);
  endtask

  task automatic set_req(input int i, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.iREQ_WR[i] = wr;
    bus.iREQ_RD[i] = rd;
    bus.iREQ_ADDR[i*AW +: AW]    = a;
    bus.iREQ_WDATA[i*DW +: DW]   = d;
    bus.iREQ_WSTRB[i*DW/8 +: DW/8] = s;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input string name, input int target);
    int k = 0;
    while (ack_cnt < target && k < 200) begin tick(); k++; end
    if (ack_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_ack_timeout: got %0d acks, required %0d", name, ack_cnt, target);
    end
  endtask

  task automatic wait_dones(input string name, input int target);
    int k = 0;
    while (done_cnt < target && k < 300) begin tick(); k++; end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got %0d dones, required %0d", name, done_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_d, sc;
    logic [31:0] a, d;
    bus.iREQ_WR = '0; bus.iREQ_RD = '0;
    bus.iREQ_ADDR = '0; bus.iREQ_WDATA = '0; bus.iREQ_WSTRB = '0;
    repeat (3) tick();

    // reset state
    checks++;
    if ({bus.oREQ_ACK, bus.oREQ_DONE, bus.oREQ_RDATA, bus.oREQ_RESP, bus.oWRITE_START,
         bus.oREAD_START, bus.oWRITE_ADDR, bus.oWRITE_DATA, bus.oWRITE_STRB, bus.oREAD_ADDR} != '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs (ack=%b ws=%b rs=%b), required all 0",
               bus.oREQ_ACK, bus.oWRITE_START, bus.oREAD_START);
    end
    rst = 1'b0;
    repeat (2) tick();

    // round robin: all four write requests held, order 0,1,2,3,0
    aw_dly = 1; b_dly = 1; same_cyc = 0; bresp_v = 2'b00;
    for (int i = 0; i < N; i++) begin
      a = 32'h2000 + 32'(i * 16);
      d = 32'hA0A0_0000 + 32'(i);
      set_req(i, 1, 0, a, d, 4'b0001 << i);
    end
    for (int k = 0; k < 5; k++) begin
      int i;
      i = k % N;
      exp_ack(i, 1, 32'h2000 + 32'(i * 16), 32'hA0A0_0000 + 32'(i), 4'b0001 << i);
      exp_done(i, 0, '0, 2'b00);
    end
    base_a = ack_cnt; base_d = done_cnt;
    wait_acks("rr", base_a + 5);
    bus.iREQ_WR = '0;
    wait_dones("rr", base_d + 5);
    repeat (3) tick();

    // single write from req0, AWREADY after 3 cycles
    aw_dly = 3; b_dly = 2; bresp_v = 2'b00;
    exp_ack(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF);
    exp_done(0, 0, '0, 2'b00);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(0, 1, 0, 32'h1000, 32'hDEADBEEF, 4'hF);
    tick();
    checks++;
    if (ack_cnt != base_a + 1) begin
      errors++;
      $display("FAIL ack_latency: got %0d acks one cycle after request, required %0d", ack_cnt - base_a, 1);
    end
    bus.iREQ_WR[0] = 1'b0;
    sc = 0;
    for (int k = 0; k < 50; k++) begin
      if (!bus.oWRITE_START) break;
      sc++;
      tick();
    end
    checks++;
    if (sc != aw_dly + 1) begin
      errors++;
      $display("FAIL start_hold: got START high %0d cycles, required %0d", sc, aw_dly + 1);
    end
    wait_dones("single_wr", base_d + 1);
    repeat (2) tick();

    // single read from req2
    aw_dly = 1; b_dly = 1; rresp_v = 2'b00; rdata_v = 32'hCAFEBABE;
    exp_ack(2, 0, 32'h1000, '0, '0);
    exp_done(2, 1, 32'hCAFEBABE, 2'b00);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(2, 0, 1, 32'h1000, '0, '0);
    wait_acks("single_rd", base_a + 1);
    bus.iREQ_RD[2] = 1'b0;
    wait_dones("single_rd", base_d + 1);
    repeat (2) tick();

    // req1 with write and read both set: write first, read on a later pass
    rdata_v = 32'h0BADF00D;
    exp_ack(1, 1, 32'h3000, 32'h12345678, 4'hC);
    exp_done(1, 0, '0, 2'b00);
    exp_ack(1, 0, 32'h3000, '0, '0);
    exp_done(1, 1, 32'h0BADF00D, 2'b00);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(1, 1, 1, 32'h3000, 32'h12345678, 4'hC);
    wait_acks("wr_rd_first", base_a + 1);
    bus.iREQ_WR[1] = 1'b0;
    wait_acks("wr_rd_second", base_a + 2);
    bus.iREQ_RD[1] = 1'b0;
    wait_dones("wr_rd", base_d + 2);
    repeat (2) tick();

    // error passthrough: SLVERR write, DECERR read
    bresp_v = 2'b10; rresp_v = 2'b11; rdata_v = 32'h55AA55AA;
    exp_ack(3, 1, 32'h5000, 32'h0000FFFF, 4'h3);
    exp_done(3, 0, '0, 2'b10);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(3, 1, 0, 32'h5000, 32'h0000FFFF, 4'h3);
    wait_acks("err_wr", base_a + 1);
    bus.iREQ_WR[3] = 1'b0;
    wait_dones("err_wr", base_d + 1);
    exp_ack(3, 0, 32'h5004, '0, '0);
    exp_done(3, 1, 32'h55AA55AA, 2'b11);
    set_req(3, 0, 1, 32'h5004, '0, '0);
    wait_acks("err_rd", base_a + 2);
    bus.iREQ_RD[3] = 1'b0;
    wait_dones("err_rd", base_d + 2);
    repeat (2) tick();

    // zero-latency slave: response in the same cycle as address acceptance
    aw_dly = 0; same_cyc = 1; bresp_v = 2'b01; rresp_v = 2'b00; rdata_v = 32'h13579BDF;
    exp_ack(0, 1, 32'h6000, 32'hFEEDFACE, 4'h5);
    exp_done(0, 0, '0, 2'b01);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(0, 1, 0, 32'h6000, 32'hFEEDFACE, 4'h5);
    wait_acks("zl_wr", base_a + 1);
    bus.iREQ_WR[0] = 1'b0;
    wait_dones("zl_wr", base_d + 1);
    exp_ack(1, 0, 32'h6008, '0, '0);
    exp_done(1, 1, 32'h13579BDF, 2'b00);
    set_req(1, 0, 1, 32'h6008, '0, '0);
    wait_acks("zl_rd", base_a + 2);
    bus.iREQ_RD[1] = 1'b0;
    wait_dones("zl_rd", base_d + 2);
    repeat (2) tick();

    // reset during W_RESP: outputs clear at once, no DONE, req0 wins next
    aw_dly = 1; b_dly = 10; same_cyc = 0; bresp_v = 2'b00;
    exp_ack(2, 1, 32'h4000, 32'h87654321, 4'hF);
    base_a = ack_cnt;
    set_req(2, 1, 0, 32'h4000, 32'h87654321, 4'hF);
    wait_acks("rst_op", base_a + 1);
    bus.iREQ_WR[2] = 1'b0;
    for (int k = 0; k < 20 && bus.oWRITE_START; k++) tick();
    repeat (2) tick();
    base_d = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.oREQ_ACK, bus.oREQ_DONE, bus.oREQ_RDATA, bus.oREQ_RESP, bus.oWRITE_START,
         bus.oREAD_START, bus.oWRITE_ADDR, bus.oWRITE_DATA, bus.oWRITE_STRB, bus.oREAD_ADDR} != '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got rdata=%h waddr=%h ws=%b, required all 0",
               bus.oREQ_RDATA, bus.oWRITE_ADDR, bus.oWRITE_START);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (15) tick();
    checks++;
    if (done_cnt != base_d) begin
      errors++;
      $display("FAIL rst_no_done: got %0d dones after reset, required 0", done_cnt - base_d);
    end
    b_dly = 1;
    exp_ack(0, 1, 32'h7000, 32'h00000000, 4'h1);
    exp_done(0, 0, '0, 2'b00);
    exp_ack(3, 1, 32'h7030, 32'h33333333, 4'h8);
    exp_done(3, 0, '0, 2'b00);
    base_a = ack_cnt; base_d = done_cnt;
    set_req(3, 1, 0, 32'h7030, 32'h33333333, 4'h8);
    set_req(0, 1, 0, 32'h7000, 32'h00000000, 4'h1);
    wait_acks("post_rst_first", base_a + 1);
    bus.iREQ_WR[0] = 1'b0;
    wait_acks("post_rst_second", base_a + 2);
    bus.iREQ_WR[3] = 1'b0;
    wait_dones("post_rst", base_d + 2);
    repeat (4) tick();

    checks++;
    if (ack_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d acks and %0d dones outstanding, required 0",
               ack_q.size(), done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
